// File: rtl/npc_mc.sv
// npc_mc: multi-cycle RV32I/RV32E integer subset core.
// It fetches over a valid/ready request/response pair and runs FETCH -> WAIT -> EXEC.
// It stops on EBREAK, or on an illegal/misaligned instruction, and keeps reporting why.
module npc_mc #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_REGS  = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_req_ready,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_result,
    output logic            retire,
    output logic            halt,
    output logic            halt_illegal,
    output logic [XLEN-1:0] a0
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("npc_mc: XLEN must be 32");
        end
        if (NR_REGS != 32 && NR_REGS != 16) begin : g_nregs_check
            $error("npc_mc: NR_REGS must be 16 or 32");
        end
    endgenerate

    localparam int          RB       = $clog2(NR_REGS);
    localparam logic [5:0]  NR       = 6'(NR_REGS);
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   alu_result_reg;
    logic [31:0]       inst_q_reg;
    logic              retire_reg;
    logic              halt_reg;
    logic              halt_illegal_reg;

    // Instruction fields of the latched word
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm, u_imm, j_imm;

    assign opcode = inst_q_reg[6:0];
    assign rd     = inst_q_reg[11:7];
    assign funct3 = inst_q_reg[14:12];
    assign rs1    = inst_q_reg[19:15];
    assign rs2    = inst_q_reg[24:20];
    assign funct7 = inst_q_reg[31:25];
    assign i_imm  = {{20{inst_q_reg[31]}}, inst_q_reg[31:20]};
    assign u_imm  = {inst_q_reg[31:12], 12'b0};
    assign j_imm  = {{11{inst_q_reg[31]}}, inst_q_reg[31], inst_q_reg[19:12],
                     inst_q_reg[20], inst_q_reg[30:21], 1'b0};

    // Register file: x0 is hardwired, every other entry is a resettable register
    logic [XLEN-1:0] rf [NR_REGS];
    logic            wr_en;
    logic [XLEN-1:0] wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < NR_REGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] q_reg;
                // Capture the EXEC result when this entry is the destination
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        q_reg <= '0;
                    else if (wr_en && rd == 5'(gi))
                        q_reg <= wr_data;
                end
                assign rf[gi] = q_reg;
            end
        end
    endgenerate

    // Operand indices beyond the implemented register count are illegal
    logic rd_ok, rs1_ok, rs2_ok;
    assign rd_ok  = ({1'b0, rd}  < NR);
    assign rs1_ok = ({1'b0, rs1} < NR);
    assign rs2_ok = ({1'b0, rs2} < NR);

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = rs1_ok ? rf[rs1[RB-1:0]] : '0;
    assign rs2_val = rs2_ok ? rf[rs2[RB-1:0]] : '0;

    logic            dec_legal, is_ebreak, is_jump, use_rd, use_rs1, use_rs2;
    logic [XLEN-1:0] next_pc;
    logic            illegal;

    // Decode and execute the latched instruction
    always_comb begin
        dec_legal = 1'b0;
        is_ebreak = 1'b0;
        is_jump   = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        wr_data   = '0;
        next_pc   = pc_reg + 32'd4;
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin         // ADDI
                dec_legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                wr_data   = rs1_val + i_imm;
            end
            7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0) begin   // ADD
                dec_legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                wr_data   = rs1_val + rs2_val;
            end
            7'b0110111: begin                               // LUI
                dec_legal = 1'b1; use_rd = 1'b1;
                wr_data   = u_imm;
            end
            7'b0010111: begin                               // AUIPC
                dec_legal = 1'b1; use_rd = 1'b1;
                wr_data   = pc_reg + u_imm;
            end
            7'b1101111: begin                               // JAL
                dec_legal = 1'b1; use_rd = 1'b1; is_jump = 1'b1;
                wr_data   = pc_reg + 32'd4;
                next_pc   = pc_reg + j_imm;
            end
            7'b1100111: if (funct3 == 3'b000) begin         // JALR
                dec_legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; is_jump = 1'b1;
                wr_data   = pc_reg + 32'd4;
                next_pc   = (rs1_val + i_imm) & ~32'd1;
            end
            7'b1110011: if (inst_q_reg == EBREAK_W) begin   // EBREAK
                dec_legal = 1'b1; is_ebreak = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = !dec_legal || (is_jump && next_pc[1]) ||
                     (use_rd && !rd_ok) || (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok);
    assign wr_en   = (state_reg == S_EXEC) && !illegal && !is_ebreak;

    // Control FSM: fetch handshake, response wait, one-cycle execute, sticky halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_FETCH;
            pc_reg           <= RESET_PC;
            inst_q_reg       <= '0;
            alu_result_reg   <= '0;
            retire_reg       <= 1'b0;
            halt_reg         <= 1'b0;
            halt_illegal_reg <= 1'b0;
        end else begin
            retire_reg <= 1'b0;
            case (state_reg)
                S_FETCH: if (ifu_req_ready) state_reg <= S_WAIT;
                S_WAIT: if (ifu_rsp_valid) begin
                    inst_q_reg <= ifu_rsp_inst;
                    state_reg  <= S_EXEC;
                end
                S_EXEC: begin
                    if (illegal) begin
                        halt_reg         <= 1'b1;
                        halt_illegal_reg <= 1'b1;
                        state_reg        <= S_HALT;
                    end else if (is_ebreak) begin
                        halt_reg   <= 1'b1;
                        retire_reg <= 1'b1;
                        state_reg  <= S_HALT;
                    end else begin
                        pc_reg         <= next_pc;
                        alu_result_reg <= wr_data;
                        retire_reg     <= 1'b1;
                        state_reg      <= S_FETCH;
                    end
                end
                default: state_reg <= S_HALT;
            endcase
        end
    end

    assign ifu_req_valid = (state_reg == S_FETCH);
    assign ifu_req_addr  = pc_reg;
    assign pc            = pc_reg;
    assign alu_result    = alu_result_reg;
    assign retire        = retire_reg;
    assign halt          = halt_reg;
    assign halt_illegal  = halt_illegal_reg;
    assign a0            = rf[10];

endmodule

// File: tb/tb_npc_mc.sv
// Testbench for npc_mc: a responder serves fetches, a reference model predicts each
// retirement into a queue, and a monitor compares on every retire pulse.
// A second instance with 16 registers shares all inputs to exercise the RV32E limits.
module tb_npc_mc;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_ready = 1'b0;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst  = '0;

    logic        ifu_req_valid, retire, halt, halt_illegal;
    logic [31:0] ifu_req_addr, pc, alu_result, a0;
    logic        ifu_req_valid_16, retire_16, halt_16, halt_illegal_16;
    logic [31:0] ifu_req_addr_16, pc_16, alu_result_16, a0_16;

    always #5 clk = ~clk;

    npc_mc #(.XLEN(32), .RESET_PC(RST_PC), .NR_REGS(32)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .pc(pc), .alu_result(alu_result), .retire(retire), .halt(halt),
        .halt_illegal(halt_illegal), .a0(a0)
    );

    npc_mc #(.XLEN(32), .RESET_PC(RST_PC), .NR_REGS(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid_16), .ifu_req_addr(ifu_req_addr_16), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .pc(pc_16), .alu_result(alu_result_16), .retire(retire_16), .halt(halt_16),
        .halt_illegal(halt_illegal_16), .a0(a0_16)
    );

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    bit abort = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] a0;
    } exp_t;
    exp_t exp_q[$];

    // Architectural reference state
    logic [31:0] m_pc, m_alu;
    logic [31:0] m_regs [32];
    bit          m_halt, m_ill, m16_halt, m16_ill;
    logic [31:0] prog_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every retire pulse consumes one predicted retirement
    always @(negedge clk) begin
        if (!rst && retire) begin
            retire_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("retire pc=%h alu_result=%h a0=%h", pc, alu_result, a0);
                chk("retire_pc", pc, e.pc);
                chk("retire_alu", alu_result, e.alu);
                chk("retire_a0", a0, e.a0);
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic void model_reset();
        m_pc = RST_PC;
        m_alu = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_halt = 0; m_ill = 0; m16_halt = 0; m16_ill = 0;
    endfunction

    // Execute one instruction on the architectural state; predict the retirement if any
    function automatic void model_step(input logic [31:0] w);
        logic [4:0]  rd  = w[11:7];
        logic [4:0]  rs1 = w[19:15];
        logic [4:0]  rs2 = w[24:20];
        logic [31:0] iimm = {{20{w[31]}}, w[31:20]};
        logic [31:0] uimm = {w[31:12], 12'b0};
        logic [31:0] jimm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        logic [31:0] a = m_regs[rs1];
        logic [31:0] b = m_regs[rs2];
        logic [31:0] res = '0;
        logic [31:0] npc = m_pc + 4;
        bit legal = 0, ebrk = 0, hi = 0;
        exp_t e;
        case (w[6:0])
            7'h13: if (w[14:12] == 0) begin legal = 1; res = a + iimm; hi = rd[4] | rs1[4]; end
            7'h33: if (w[14:12] == 0 && w[31:25] == 0) begin
                legal = 1; res = a + b; hi = rd[4] | rs1[4] | rs2[4];
            end
            7'h37: begin legal = 1; res = uimm; hi = rd[4]; end
            7'h17: begin legal = 1; res = m_pc + uimm; hi = rd[4]; end
            7'h6f: begin
                res = m_pc + 4; npc = m_pc + jimm; hi = rd[4]; legal = (npc[1] == 0);
            end
            7'h67: if (w[14:12] == 0) begin
                res = m_pc + 4; npc = (a + iimm) & 32'hFFFF_FFFE; hi = rd[4] | rs1[4];
                legal = (npc[1] == 0);
            end
            7'h73: if (w == EBRK) begin legal = 1; ebrk = 1; end
            default: ;
        endcase
        if (!m16_halt) begin
            if (!legal || hi) begin m16_halt = 1; m16_ill = 1; end
            else if (ebrk) m16_halt = 1;
        end
        if (!legal) begin
            m_halt = 1; m_ill = 1;
        end else if (ebrk) begin
            m_halt = 1;
            e.pc = m_pc; e.alu = m_alu; e.a0 = m_regs[10];
            exp_q.push_back(e);
        end else begin
            if (rd != 0) m_regs[rd] = res;
            m_alu = res;
            m_pc = npc;
            e.pc = m_pc; e.alu = m_alu; e.a0 = m_regs[10];
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] gen_inst();
        int unsigned r = $urandom_range(0, 99);
        logic [4:0]  rd  = 5'($urandom_range(0, 31));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [11:0] imm12 = 12'($urandom);
        logic [19:0] imm20 = 20'($urandom);
        int off;
        if (r < 25) return enc_i(7'h13, rd, rs1, imm12);
        if (r < 45) return enc_add(rd, rs1, rs2);
        if (r < 55) return enc_u(7'h37, rd, imm20);
        if (r < 65) return enc_u(7'h17, rd, imm20);
        if (r < 75) begin
            off = (int'($urandom_range(0, 511)) - 256) * 4;
            if (r == 74) off = off + 2;
            return enc_jal(rd, 21'(off));
        end
        if (r < 82) return enc_i(7'h67, rd, 5'd0, {imm12[11:2], 2'b00});
        if (r < 85) return enc_i(7'h67, rd, rs1, imm12);
        if (r < 98) return enc_i(7'h13, rd, rs1, imm12);
        if (r == 98) return enc_i(7'h03, rd, rs1, imm12);
        return $urandom;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        exp_q.delete();
        model_reset();
        abort = 0;
        @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_flags", {29'd0, retire, halt, halt_illegal}, 32'd0);
        chk("rst_a0", a0, 32'd0);
        chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Serve one fetch with the given request/response delays (negative means random)
    task automatic serve(input logic [31:0] inst, input int d_req, input int d_rsp);
        int n = 0;
        int dq = (d_req < 0) ? int'($urandom_range(0, 3)) : d_req;
        int dp = (d_rsp < 0) ? int'($urandom_range(0, 3)) : d_rsp;
        logic [31:0] addr;
        while (ifu_req_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++; abort = 1;
            $display("FAIL req_timeout: got no request within 50 cycles expected a request");
            return;
        end
        addr = ifu_req_addr;
        chk("req_addr", addr, m_pc);
        for (int i = 0; i < dq; i++) begin
            @(posedge clk); #1;
            chk("req_valid_held", {31'd0, ifu_req_valid}, 32'd1);
            chk("req_addr_stable", ifu_req_addr, addr);
        end
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        chk("wait_no_req", {31'd0, ifu_req_valid}, 32'd0);
        for (int i = 0; i < dp; i++) begin
            @(posedge clk); #1;
            chk("wait_no_dup_req", {31'd0, ifu_req_valid}, 32'd0);
        end
        $display("fetch addr=%h inst=%h", addr, inst);
        model_step(inst);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = $urandom;
        @(posedge clk); #1;
        if (m_ill) begin
            chk("illegal_no_retire", {31'd0, retire}, 32'd0);
            chk("illegal_halt", {30'd0, halt, halt_illegal}, 32'd3);
        end else begin
            chk("retire_latency", {31'd0, retire}, 32'd1);
        end
    endtask

    task automatic finish_prog();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_req_after_halt", {31'd0, ifu_req_valid}, 32'd0);
        end
        chk("end_halt", {31'd0, halt}, {31'd0, m_halt});
        chk("end_halt_illegal", {31'd0, halt_illegal}, {31'd0, m_ill});
        chk("end_pc", pc, m_pc);
        chk("end_alu", alu_result, m_alu);
        chk("end_a0", a0, m_regs[10]);
        chk("end_pending", exp_q.size(), 32'd0);
        chk("rv32e_halt", {31'd0, halt_16}, {31'd0, m16_halt});
        chk("rv32e_halt_illegal", {31'd0, halt_illegal_16}, {31'd0, m16_ill});
    endtask

    task automatic run_prog(input string name, input int d_req, input int d_rsp);
        $display("program %s", name);
        do_reset();
        foreach (prog_q[i]) begin
            if (m_halt || abort) break;
            serve(prog_q[i], d_req, d_rsp);
        end
        if (!abort) finish_prog();
    endtask

    initial begin
        int rc;

        // Zero-wait ADDI: retire three cycles after the request handshake
        prog_q = {enc_i(7'h13, 5'd1, 5'd0, 12'd5), enc_add(5'd10, 5'd1, 5'd0), EBRK};
        run_prog("addi_zero_wait", 0, 0);
        chk("addi_a0", a0, 32'd5);

        // Slow memory: one retire per instruction, no duplicate requests
        prog_q = {enc_i(7'h13, 5'd1, 5'd0, 12'd5), EBRK};
        rc = retire_cnt;
        run_prog("slow_memory", 4, 3);
        chk("slow_retire_count", retire_cnt - rc, 32'd2);

        prog_q = {enc_u(7'h37, 5'd10, 20'h12345), enc_i(7'h13, 5'd10, 5'd10, 12'hFFF), EBRK};
        run_prog("lui_addi_ebreak", -1, -1);
        chk("lui_a0", a0, 32'h1234_4FFF);
        chk("lui_good_trap", {30'd0, halt, halt_illegal}, 32'd2);

        prog_q = {enc_jal(5'd1, 21'd8), enc_i(7'h67, 5'd1, 5'd1, 12'd0), enc_add(5'd10, 5'd1, 5'd0), EBRK};
        run_prog("jal_jalr", -1, -1);
        chk("jalr_link", a0, 32'h8000_000C);
        chk("jalr_final_pc", pc, 32'h8000_0008);

        prog_q = {enc_i(7'h13, 5'd0, 5'd0, 12'd7), enc_add(5'd10, 5'd0, 5'd0), EBRK};
        run_prog("x0_write", 0, 0);
        chk("x0_reads_zero", a0, 32'd0);

        prog_q = {enc_i(7'h13, 5'd10, 5'd0, 12'd3), enc_i(7'h03, 5'd1, 5'd0, 12'd0), EBRK};
        rc = retire_cnt;
        run_prog("load_illegal", 0, 1);
        chk("load_retire_count", retire_cnt - rc, 32'd1);
        chk("load_bad_trap", {30'd0, halt, halt_illegal}, 32'd3);

        prog_q = {enc_i(7'h13, 5'd20, 5'd0, 12'd1), EBRK};
        run_prog("rv32e_index", -1, -1);
        chk("rv32e_x20_illegal", {31'd0, halt_illegal_16}, 32'd1);

        prog_q = {enc_jal(5'd1, 21'd6)};
        run_prog("jal_misaligned", 0, 0);

        // Reset while waiting for a response; the stale response must be ignored
        $display("program reset_in_wait");
        do_reset();
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_fetch", {31'd0, ifu_req_valid}, 32'd1);
        chk("async_rst_pc", pc, RST_PC);
        @(posedge clk); #1;
        rst = 1'b0;
        rc = retire_cnt;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = enc_i(7'h13, 5'd10, 5'd0, 12'd99);
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        chk("stale_rsp_still_fetch", {31'd0, ifu_req_valid}, 32'd1);
        @(posedge clk); #1;
        chk("stale_rsp_no_retire", retire_cnt - rc, 32'd0);
        chk("stale_rsp_pc", pc, RST_PC);
        serve(enc_i(7'h13, 5'd1, 5'd0, 12'd5), 0, 0);
        if (!abort) serve(EBRK, 0, 0);
        if (!abort) finish_prog();

        // Randomised programs
        for (int p = 0; p < 20; p++) begin
            $display("program random_%0d", p);
            do_reset();
            for (int k = 0; k < 25 && !m_halt && !abort; k++)
                serve(gen_inst(), -1, -1);
            if (!m_halt && !abort) serve(EBRK, -1, -1);
            if (!abort) finish_prog();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
